// File: rtl/input_loader.sv
// Byte-stream loader for the layer-one image (28x28 bits) and eight 3x3 kernels; bytes land in storage one cycle after acceptance.
// Backpressure: load_ready drops once all 107 bytes are stored or outside LOAD; data_valid without load_ready is ignored.
module input_loader (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       state,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             load_ready,
  output logic [27:0]      pixels  [27:0],
  output logic [2:0][2:0]  weights [7:0],
  output logic [6:0]       byte_cnt,
  output logic             load_done
);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_LOAD  = 3'b001;
  localparam int         N_BYTES  = 107;
  localparam int         N_BITS   = N_BYTES * 8;
  localparam int         PIX_BITS = 28 * 28;

  // Flat image of the whole stream: stream bit n lives at store[n], so every
  // byte is a simple 8-bit slice and the arrays are pure rewiring below.
  logic [N_BITS-1:0] store;
  logic              accept;
  logic [9:0]        wr_base;

  assign load_ready = (state == ST_LOAD) && !load_done;
  assign accept     = load_ready && data_valid;
  assign wr_base    = {byte_cnt, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      store     <= '0;
      byte_cnt  <= '0;
      load_done <= 1'b0;
    end else if (state == ST_IDLE) begin
      // Arrays are kept so a finished image survives the return to IDLE.
      byte_cnt  <= '0;
      load_done <= 1'b0;
    end else if (accept) begin
      store[wr_base +: 8] <= data_in;
      byte_cnt            <= byte_cnt + 7'd1;
      load_done           <= (byte_cnt == 7'(N_BYTES - 1));
    end
  end

  for (genvar r = 0; r < 28; r++) begin : g_pix
    assign pixels[r] = store[28*r +: 28];
  end

  // Packed [2:0][2:0] places kernel element (r,c) at bit 3r+c, matching m%9.
  for (genvar k = 0; k < 8; k++) begin : g_wgt
    assign weights[k] = store[PIX_BITS + 9*k +: 9];
  end

endmodule
